// File: rtl/mem_stage_wait_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_wait_ctrl
//
// MEM pipeline stage directly downstream of EXE. alu_res_in is used as a byte
// address and val_r_m_in as store data for an internal word-addressed data
// memory. That memory takes a fixed WAIT_CYCLES clocks per access. While an
// access is in flight, freeze tells IF..EXE to hold. Results are registered
// into the MEM/WB boundary on every edge where freeze is low.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   wb_en_in      writeback enable from the EXE register
//   mem_r_en_in   load request
//   mem_w_en_in   store request (wins over a load if both are set)
//   dest_in       destination register
//   alu_res_in    ALU result / byte address
//   val_r_m_in    store data (post-forwarding)
//   freeze        1 = upstream must hold all inputs stable
//   wb_en_out     registered to WB
//   mem_r_en_out  registered to WB (selects mem_data_out)
//   dest_out      registered to WB
//   alu_res_out   registered to WB
//   mem_data_out  registered load data (0 for non-loads)
//   addr_err      registered; 1 for one WB slot after an out-of-range access
// ---------------------------------------------------------------------------
module mem_stage_wait_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [3:0]        dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_r_m_in,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [3:0]        dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [DATA_W-1:0] BASE      = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] DEPTH_W   = DATA_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              is_store;
  logic              is_load;
  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] word;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              commit;

  // A simultaneous load+store request is executed as a store.
  assign req      = mem_r_en_in | mem_w_en_in;
  assign is_store = mem_w_en_in;
  assign is_load  = mem_r_en_in & ~mem_w_en_in;

  // Low two address bits are dropped; addresses below BASE wrap to huge
  // offsets, but the explicit >= test rejects them regardless.
  assign offset   = alu_res_in - BASE;
  assign word     = offset >> 2;
  assign in_range = (alu_res_in >= BASE) && (word < DEPTH_W);
  assign idx      = word[IDX_W-1:0];

  // Last access cycle: the store lands / the load is captured on this edge.
  assign commit   = (state == S_ACCESS) && (cnt == '0);

  assign freeze   = (state == S_ACCESS) || ((state == S_IDLE) && req);

  // NOTE: the data array has no reset; its contents survive rst and only a
  // committed in-range store changes a word. Keeping it out of the reset
  // block lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit && is_store && in_range) begin
      mem[idx] <= val_r_m_in;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_ACCESS;
            cnt   <= CNT_START;
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rdata <= (is_load && in_range) ? mem[idx] : '0;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB boundary. It only advances when upstream advances, so a memory op
  // is written exactly once, from the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      addr_err     <= 1'b0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      dest_out     <= dest_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= is_load ? rdata : '0;
      addr_err     <= req & ~in_range;
    end
  end

endmodule

// File: tb/tb_mem_stage_wait_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_wait_ctrl
//
// Instruction-level bench for mem_stage_wait_ctrl. Each instruction is held on
// the inputs for its expected latency (1 cycle for ALU ops, WAIT+2 for memory
// ops). Once that latency has elapsed, a word-array model produces the
// expected WB contents. A negedge compare process checks freeze and every WB
// output against the model on every cycle. Directed cases pin the model with
// literal values.
// ---------------------------------------------------------------------------
module tb_mem_stage_wait_ctrl;

  localparam int WAIT  = 4;
  localparam int BASE  = 1024;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic        wb_en;
    logic        r;
    logic        w;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] val;
  } instr_t;

  typedef struct packed {
    logic        wb_en;
    logic        r_en;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_r_m_in;
  logic        freeze, wb_en_out, mem_r_en_out, addr_err;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;

  mem_stage_wait_ctrl #(
    .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          freeze_cnt = 0;
  bit          chk_en = 1'b0;
  bit          exp_freeze = 1'b0;
  wb_t         exp_wb = '0;
  logic [31:0] mdl_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (freeze === 1'b1) freeze_cnt++;
      check("freeze",       32'(freeze),       32'(exp_freeze));
      check("wb_en_out",    32'(wb_en_out),    32'(exp_wb.wb_en));
      check("mem_r_en_out", 32'(mem_r_en_out), 32'(exp_wb.r_en));
      check("dest_out",     32'(dest_out),     32'(exp_wb.dest));
      check("alu_res_out",  alu_res_out,       exp_wb.alu);
      check("mem_data_out", mem_data_out,      exp_wb.data);
      check("addr_err",     32'(addr_err),     32'(exp_wb.err));
    end
  end

  task automatic drive(input instr_t t);
    wb_en_in    = t.wb_en;
    mem_r_en_in = t.r;
    mem_w_en_in = t.w;
    dest_in     = t.dest;
    alu_res_in  = t.alu;
    val_r_m_in  = t.val;
  endtask

  // Present one instruction, hold it for its latency, then retire it in the
  // model. Called #1 after a rising edge; returns #1 after the WB edge.
  task automatic issue(input instr_t t);
    bit     is_mem;
    bit     ok;
    int     lat;
    int     idx;
    longint a;
    wb_t    res;
    is_mem = t.r | t.w;
    lat    = is_mem ? WAIT + 2 : 1;
    drive(t);
    for (int k = 0; k < lat; k++) begin
      exp_freeze = is_mem && (k <= WAIT);
      @(posedge clk);
      #1;
    end
    a   = longint'(t.alu);
    ok  = (a >= BASE) && ((a - BASE) / 4 < DEPTH);
    idx = ok ? int'((a - BASE) / 4) : 0;
    res.wb_en = t.wb_en;
    res.r_en  = t.r;
    res.dest  = t.dest;
    res.alu   = t.alu;
    res.data  = (t.r && !t.w && ok) ? mdl_mem[idx] : 32'h0;
    res.err   = is_mem && !ok;
    if (t.w && ok) mdl_mem[idx] = t.val;
    exp_wb     = res;
    exp_freeze = 1'b0;
  endtask

  function automatic instr_t mk(input bit r, input bit w, input logic [31:0] alu,
                                input logic [31:0] val, input logic [3:0] dest,
                                input bit wb_en);
    instr_t t;
    t.wb_en = wb_en; t.r = r; t.w = w; t.dest = dest; t.alu = alu; t.val = val;
    return t;
  endfunction

  instr_t nop = '0;

  initial begin
    logic [31:0] saved_w1, saved_w0, saved_w63;
    drive(nop);
    rst = 1'b1;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_freeze", 32'(freeze), 32'h0);
    check("reset_alu", alu_res_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word so later loads have known contents.
    for (int i = 0; i < DEPTH; i++)
      issue(mk(1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, 4'(i), 1'b0));

    // Reset while a store to word 1 is mid-access.
    saved_w1 = mdl_mem[1];
    drive(mk(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 4'd1, 1'b0));
    exp_freeze = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    drive(nop);
    exp_freeze = 1'b0;
    exp_wb     = '0;
    #1;
    check("t1_freeze_drop", 32'(freeze), 32'h0);
    check("t1_wb_zero", {wb_en_out, mem_r_en_out, addr_err, dest_out}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(mk(1'b1, 1'b0, 32'd1028, 32'h0, 4'd2, 1'b1));
    check("t1_word1_kept", mem_data_out, saved_w1);

    // Plain ALU op: one cycle, no freeze.
    freeze_cnt = 0;
    issue(mk(1'b0, 1'b0, 32'h55, 32'h0, 4'd3, 1'b1));
    check("t2_alu", alu_res_out, 32'h55);
    check("t2_dest", 32'(dest_out), 32'd3);
    check("t2_wb_en", 32'(wb_en_out), 32'd1);
    check("t2_no_freeze", 32'(freeze_cnt), 32'd0);

    // Store then load of the same word, different low address bits.
    freeze_cnt = 0;
    issue(mk(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0, 1'b0));
    check("t3_store_freeze", 32'(freeze_cnt), 32'd5);
    freeze_cnt = 0;
    issue(mk(1'b1, 1'b0, 32'd1034, 32'h0, 4'd7, 1'b1));
    check("t3_load_freeze", 32'(freeze_cnt), 32'd5);
    check("t3_load_data", mem_data_out, 32'hDEAD_BEEF);
    check("t3_load_r_en", 32'(mem_r_en_out), 32'd1);

    // Out-of-range accesses on both sides of the window.
    issue(mk(1'b1, 1'b0, 32'd1020, 32'h0, 4'd4, 1'b1));
    check("t4_low_err", 32'(addr_err), 32'd1);
    check("t4_low_data", mem_data_out, 32'h0);
    issue(mk(1'b1, 1'b0, 32'(BASE + 4 * DEPTH), 32'h0, 4'd5, 1'b1));
    check("t4_high_err", 32'(addr_err), 32'd1);
    check("t4_high_data", mem_data_out, 32'h0);
    saved_w0  = mdl_mem[0];
    saved_w63 = mdl_mem[63];
    issue(mk(1'b0, 1'b1, 32'd1280, 32'h1234_5678, 4'd6, 1'b0));
    issue(mk(1'b1, 1'b0, 32'd1024, 32'h0, 4'd6, 1'b1));
    check("t4_word0_kept", mem_data_out, saved_w0);
    issue(mk(1'b1, 1'b0, 32'd1276, 32'h0, 4'd6, 1'b1));
    check("t4_word63_kept", mem_data_out, saved_w63);

    // Back-to-back loads with no idle gap.
    issue(mk(1'b0, 1'b1, 32'd1040, 32'hA5A5_0001, 4'd0, 1'b0));
    issue(mk(1'b0, 1'b1, 32'd1044, 32'h5A5A_0002, 4'd0, 1'b0));
    freeze_cnt = 0;
    issue(mk(1'b1, 1'b0, 32'd1040, 32'h0, 4'd8, 1'b1));
    check("t5_first", mem_data_out, 32'hA5A5_0001);
    issue(mk(1'b1, 1'b0, 32'd1044, 32'h0, 4'd9, 1'b1));
    check("t5_second", mem_data_out, 32'h5A5A_0002);
    check("t5_dest", 32'(dest_out), 32'd9);
    check("t5_freeze_total", 32'(freeze_cnt), 32'd10);

    // Random mix of ALU ops, loads, stores and load+store, addresses
    // straddling both ends of the memory window.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      issue(mk(kind == 1 || kind == 3, kind == 2 || kind == 3,
               32'(BASE - 16 + int'($urandom_range(0, 4 * DEPTH + 31))),
               $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
    end

    issue(nop);
    issue(nop);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
